// File: rtl/gaus_rng_arbiter.sv
// gaus_rng_arbiter: shares one Gaussian PRNG among NUM_REQ requesters.
// Sequences seed load + warm-up, then hands out one sample per cycle
// with round-robin fairness and a saturating draw counter.
module gaus_rng_arbiter #(
  parameter int unsigned       NUM_REQ       = 4,
  parameter int unsigned       WIDTH         = 56,
  parameter int unsigned       WARMUP_CYCLES = 16,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED  = 56'h00A5_5A3C_C3F0_0F
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic               reseed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [WIDTH-1:0]   rand_out,
  output logic               ready,
  output logic [31:0]        draw_count,
  output logic               gen_rst_n,
  output logic [WIDTH-1:0]   gen_seed,
  input  logic [WIDTH-1:0]   gen_data
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESEED,
    ST_WARMUP,
    ST_SERVE
  } state_t;

  state_t           state;
  logic [7:0]       warm_cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             granted;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;

  assign rand_out = gen_data;

  // Round-robin pick: first requester at or after ptr, modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    granted   = 1'b0;
    sum       = '0;
    idx       = '0;
    if (ready && !reseed) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_REQ))
          sum = sum - SUM_W'(NUM_REQ);
        idx = sum[PTR_W-1:0];
        if (!granted && req[idx]) begin
          granted    = 1'b1;
          grant_idx  = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    next_ptr = '0;
    if (grant_idx != PTR_W'(NUM_REQ - 1))
      next_ptr = grant_idx + PTR_W'(1);
  end

  // Seed-load / warm-up / serve sequencer; reseed overrides every state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_RESEED;
      gen_rst_n <= 1'b0;
      gen_seed  <= DEFAULT_SEED;
      warm_cnt  <= '0;
      ready     <= 1'b0;
    end else if (reseed) begin
      state     <= ST_RESEED;
      gen_rst_n <= 1'b0;
      gen_seed  <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
      warm_cnt  <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_RESEED: begin
          state     <= ST_WARMUP;
          gen_rst_n <= 1'b1;
        end
        ST_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state <= ST_SERVE;
            ready <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 8'd1;
          end
        end
        ST_SERVE: ;
        default: state <= ST_RESEED;
      endcase
    end
  end

  // Arbitration pointer and saturating draw counter (not cleared by reseed).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr        <= '0;
      draw_count <= '0;
    end else if (granted) begin
      ptr <= next_ptr;
      if (draw_count != '1)
        draw_count <= draw_count + 32'd1;
    end
  end

endmodule

// File: doc/gaus_rng_arbiter.md
# gaus_rng_arbiter

Shares one 56-bit Gaussian pseudo-random source among NUM_REQ lattice-update requesters with round-robin fairness. It sequences the generator's seed load and warm-up after reset or on a reseed command. It gates draws until the stream is valid and counts samples handed out. It sits between the collision/noise units and the single Gaussian generator instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..16; need not be a power of two.
- WIDTH, 56: sample width; must match the generator.
- WARMUP_CYCLES, 16: generator clock cycles discarded after each seed load, 1..255.
- DEFAULT_SEED, 56'h00A5_5A3C_C3F0_0F: seed used after reset and substituted for any zero seed.

- Clk  in  1  clock; all registers update on the rising edge.
- Reset  in  1  reset, asynchronous, active-low.
- seed_in  in  WIDTH  candidate seed, sampled only when reseed=1.
- reseed  in  1  single-cycle reseed command.
- req  in  NUM_REQ  level request, one bit per requester.
- grant  out  NUM_REQ  one-hot grant, combinational; the requester captures rand_out on the edge where its grant is high.
- rand_out  out  WIDTH  sample, combinational pass-through of gen_data.
- ready  out  1  registered; high only in SERVE.
- draw_count  out  32  registered count of granted draws; saturates at 32'hFFFF_FFFF.
- gen_rst_n  out  1  registered; drives the generator's Reset.
- gen_seed  out  WIDTH  registered seed presented to the generator.
- gen_data  in  WIDTH  generator output; advances every cycle while gen_rst_n=1.

## Operation
- Reset values: state=RESEED, gen_rst_n=0, gen_seed=DEFAULT_SEED, ptr=0, warm counter=0, ready=0, draw_count=0. grant=0 because ready=0.
- FSM states: RESEED, WARMUP, SERVE.
  - RESEED: gen_rst_n=0, so the generator holds gen_seed. Next state is WARMUP, and gen_rst_n<=1.
  - WARMUP: the counter increments each cycle. When it reaches WARMUP_CYCLES-1, next state is SERVE, and ready<=1.
  - SERVE: arbitration is active.
- Reseed is accepted in every state and takes priority over all other transitions.
  - gen_seed<=(seed_in==0 ? DEFAULT_SEED : seed_in).
  - State<=RESEED, gen_rst_n<=0, ready<=0, counter<=0.
  - If reseed arrives while already in RESEED, the new seed is loaded and the block spends one more cycle in RESEED.
  - If reseed arrives during WARMUP, the warm-up restarts from zero.
- Arbitration:
  - grant is nonzero only when ready=1 and reseed=0.
  - Select the first set req bit at index ptr, ptr+1, … (mod NUM_REQ).
  - On a grant to index i, ptr<=(i+1) mod NUM_REQ.
  - With no req, grant=0 and ptr holds.
  - At most one grant per cycle, so each generator sample goes to at most one requester.
- draw_count increments on every edge where grant≠0, unless saturated. Reseed does not clear it; only Reset does.
- Reset asserted mid-operation returns every register to its reset value immediately, and grant drops at once.

## Timing
- Reset deassert, then edge 1: RESEED→WARMUP, gen_rst_n=1.
- Edge 1+WARMUP_CYCLES: ready=1. With defaults that is edge 17, and the first grant is possible in the cycle after edge 17.
- Reseed sampled at edge E: no grant in the cycle containing E; gen_rst_n=0 after E; gen_rst_n=1 after E+1; ready=1 after E+1+WARMUP_CYCLES.
- Grant latency: zero cycles; grant is combinational from req in the same cycle.
- Requesters drop req in the cycle after their last needed grant.
- Throughput: one sample per cycle.
- Fairness: with all requesters asserting, each is granted exactly once every NUM_REQ cycles.
- A requester is never waited on for more than NUM_REQ-1 grants to others.
- Wrap: after a grant to NUM_REQ-1, ptr=0.

## Test plan
- Reset release, req=4'b1111 held: grant=0 through edge 16. Grants then follow 0001,0010,0100,1000,0001…; ready=1 from edge 17. After 8 granted cycles, draw_count=8.
- Sparse requests in SERVE: req=4'b1010 with ptr=0 → grant 0010, then 1000, then 0010. req=0 → grant=0, ptr unchanged, draw_count unchanged.
- Reseed with seed_in=56'h1234 during SERVE, req=4'b0001:
  - Grant=0 in the reseed cycle; gen_rst_n=0 for one cycle; gen_seed=56'h1234.
  - ready=0 for 17 cycles. The first granted rand_out equals the generator's output for seed 56'h1234 after 16 warm-up cycles.
- Zero-seed substitution and repeated reseed: reseed with seed_in=0 → gen_seed=DEFAULT_SEED. Reseed again during WARMUP cycle 5 → counter restarts, and ready is delayed to 17 cycles after the second reseed.
- Async Reset dropped mid-SERVE while grant=0100: grant, ready, gen_rst_n and draw_count go to 0 immediately, before the next edge. Recovery repeats the first scenario exactly.
- Saturation: force draw_count to 32'hFFFF_FFFE, grant three times → the count stops at 32'hFFFF_FFFF.
